// File: rtl/systolic_filter_seq_ctrl.sv
// Sequencer for the systolic matched-filter chain: flush, fill, run and drain phases,
// sample-gap resynchronisation and per-lane output overflow monitoring.
`timescale 1ns/1ps
module systolic_filter_seq_ctrl #(
  parameter int INBITS       = 12,
  parameter int OUTBITS      = 16,
  parameter int FLUSH_CYCLES = 8,
  parameter int LATENCY      = 9,
  parameter int CNTW         = $clog2(((FLUSH_CYCLES > LATENCY) ? FLUSH_CYCLES : LATENCY) + 1)
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        run_i,
  input  logic        samp_valid_i,
  input  logic [23:0] lane0_i,
  input  logic [23:0] lane1_i,
  input  logic        ovf_clr_i,
  output logic        zero_o,
  output logic        out_valid_o,
  output logic        busy_o,
  output logic [2:0]  state_o,
  output logic [1:0]  ovf_o,
  output logic [7:0]  resync_cnt_o
);

  localparam int TOPW = 25 - OUTBITS;

  if (OUTBITS < INBITS + 1) begin : g_bad_width
    $error("OUTBITS must exceed INBITS");
  end

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FLUSH = 3'd1,
    S_FILL  = 3'd2,
    S_RUN   = 3'd3,
    S_DRAIN = 3'd4
  } state_e;

  state_e            state_r;
  state_e            state_nx_s;
  logic [CNTW-1:0]   cnt_r;
  logic [CNTW-1:0]   cnt_nx_s;
  logic              resync_inc_s;
  logic              zero_r;
  logic              valid_r;
  logic              busy_r;
  logic [1:0]        ovf_r;
  logic [1:0]        ovf_set_s;
  logic [7:0]        resync_r;

  // A lane result is out of range when its bits above the legal sign bit are not a pure sign extension.
  function automatic logic lane_ovf(input logic [23:0] lane);
    logic [TOPW-1:0] top_s;
    top_s = lane[23:OUTBITS-1];
    return !((&top_s) | ~(|top_s));
  endfunction

  // Next-state and counter reload logic.
  always_comb begin
    state_nx_s   = S_IDLE;
    cnt_nx_s     = cnt_r - CNTW'(1);
    resync_inc_s = 1'b0;
    case (state_r)
      S_IDLE: begin
        if (run_i) begin
          state_nx_s = S_FLUSH;
          cnt_nx_s   = CNTW'(FLUSH_CYCLES - 1);
        end else begin
          state_nx_s = S_IDLE;
        end
      end
      S_FLUSH: begin
        if (!run_i) begin
          state_nx_s = S_IDLE;
        end else if (cnt_r == CNTW'(0)) begin
          state_nx_s = S_FILL;
          cnt_nx_s   = CNTW'(LATENCY - 1);
        end else begin
          state_nx_s = S_FLUSH;
        end
      end
      S_FILL: begin
        if (!run_i) begin
          state_nx_s = S_DRAIN;
          cnt_nx_s   = CNTW'(LATENCY - 1);
        end else if (!samp_valid_i) begin
          state_nx_s   = S_FLUSH;
          cnt_nx_s     = CNTW'(FLUSH_CYCLES - 1);
          resync_inc_s = 1'b1;
        end else if (cnt_r == CNTW'(0)) begin
          state_nx_s = S_RUN;
        end else begin
          state_nx_s = S_FILL;
        end
      end
      S_RUN: begin
        if (!run_i) begin
          state_nx_s = S_DRAIN;
          cnt_nx_s   = CNTW'(LATENCY - 1);
        end else if (!samp_valid_i) begin
          state_nx_s   = S_FLUSH;
          cnt_nx_s     = CNTW'(FLUSH_CYCLES - 1);
          resync_inc_s = 1'b1;
        end else begin
          state_nx_s = S_RUN;
        end
      end
      S_DRAIN: begin
        if (cnt_r == CNTW'(0)) begin
          state_nx_s = S_IDLE;
        end else begin
          state_nx_s = S_DRAIN;
        end
      end
      default: begin
        state_nx_s = S_IDLE;
      end
    endcase
  end

  // State, counter and Moore outputs registered together so outputs track the state register exactly.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_r  <= S_IDLE;
      cnt_r    <= '0;
      zero_r   <= 1'b1;
      valid_r  <= 1'b0;
      busy_r   <= 1'b0;
      resync_r <= 8'd0;
    end else begin
      state_r <= state_nx_s;
      cnt_r   <= cnt_nx_s;
      zero_r  <= (state_nx_s != S_FILL) && (state_nx_s != S_RUN);
      valid_r <= (state_nx_s == S_RUN);
      busy_r  <= (state_nx_s != S_IDLE);
      if (resync_inc_s && (resync_r != 8'hFF)) begin
        resync_r <= resync_r + 8'd1;
      end else begin
        resync_r <= resync_r;
      end
    end
  end

  assign ovf_set_s = {lane_ovf(lane1_i), lane_ovf(lane0_i)} & {2{valid_r}};

  // Sticky overflow flags; a new violation outranks a simultaneous clear.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ovf_r <= 2'b00;
    end else if (ovf_clr_i) begin
      ovf_r <= ovf_set_s;
    end else begin
      ovf_r <= ovf_r | ovf_set_s;
    end
  end

  assign zero_o       = zero_r;
  assign out_valid_o  = valid_r;
  assign busy_o       = busy_r;
  assign state_o      = state_r;
  assign ovf_o        = ovf_r;
  assign resync_cnt_o = resync_r;

endmodule

// File: tb/tb_systolic_filter_seq_ctrl.sv
// Self-checking bench: phase/duration reference model feeds a scoreboard queue,
// a negedge monitor compares every cycle, directed checks cover the timing corners.
`timescale 1ns/1ps
module tb_systolic_filter_seq_ctrl;

  localparam int F  = 8;
  localparam int L  = 9;
  localparam int OB = 16;
  localparam int PH_IDLE = 0, PH_FLUSH = 1, PH_FILL = 2, PH_RUN = 3, PH_DRAIN = 4;

  logic        clk = 1'b0;
  logic        rst_ni = 1'b0;
  logic        run = 1'b0;
  logic        sv = 1'b1;
  logic [23:0] l0 = 24'd0;
  logic [23:0] l1 = 24'd0;
  logic        clr = 1'b0;
  logic        zero, valid, busy;
  logic [2:0]  st;
  logic [1:0]  ovf;
  logic [7:0]  resync;

  int total = 0;
  int bad = 0;

  int          m_phase = PH_IDLE;
  int          m_elapsed = 0;
  int          m_resync = 0;
  logic [1:0]  m_ovf = 2'b00;
  logic [15:0] sb[$];

  systolic_filter_seq_ctrl #(.INBITS(12), .OUTBITS(OB), .FLUSH_CYCLES(F), .LATENCY(L)) dut (
    .clk_i(clk), .rst_ni(rst_ni), .run_i(run), .samp_valid_i(sv),
    .lane0_i(l0), .lane1_i(l1), .ovf_clr_i(clr),
    .zero_o(zero), .out_valid_o(valid), .busy_o(busy), .state_o(st),
    .ovf_o(ovf), .resync_cnt_o(resync)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit out_of_range(input logic [23:0] v);
    int s;
    s = int'($signed(v));
    return (s > (1 << (OB - 1)) - 1) || (s < -(1 << (OB - 1)));
  endfunction

  function automatic logic [15:0] expect_word();
    logic z;
    z = (m_phase == PH_IDLE) || (m_phase == PH_FLUSH) || (m_phase == PH_DRAIN);
    return {3'(m_phase), z, m_phase == PH_RUN, m_phase != PH_IDLE, m_ovf, 8'(m_resync)};
  endfunction

  task automatic go(input int ph);
    m_phase   = ph;
    m_elapsed = 0;
  endtask

  task automatic model_step();
    logic [1:0] set;
    set = 2'b00;
    if (m_phase == PH_RUN) set = {out_of_range(l1), out_of_range(l0)};
    m_ovf = (clr ? 2'b00 : m_ovf) | set;
    case (m_phase)
      PH_IDLE:  if (run) go(PH_FLUSH);
      PH_FLUSH: if (!run) go(PH_IDLE);
                else if (m_elapsed == F - 1) go(PH_FILL);
                else m_elapsed++;
      PH_FILL:  if (!run) go(PH_DRAIN);
                else if (!sv) begin go(PH_FLUSH); m_resync = (m_resync < 255) ? m_resync + 1 : 255; end
                else if (m_elapsed == L - 1) go(PH_RUN);
                else m_elapsed++;
      PH_RUN:   if (!run) go(PH_DRAIN);
                else if (!sv) begin go(PH_FLUSH); m_resync = (m_resync < 255) ? m_resync + 1 : 255; end
      PH_DRAIN: if (m_elapsed == L - 1) go(PH_IDLE);
                else m_elapsed++;
      default:  go(PH_IDLE);
    endcase
  endtask

  initial forever begin
    @(posedge clk or negedge rst_ni);
    if (!rst_ni) begin
      m_phase = PH_IDLE; m_elapsed = 0; m_resync = 0; m_ovf = 2'b00;
      sb.delete();
    end else begin
      model_step();
    end
    sb.push_back(expect_word());
  end

  initial forever begin
    @(negedge clk);
    if (sb.size() > 0) begin
      logic [15:0] e;
      e = sb.pop_front();
      chk("scoreboard", {16'd0, st, zero, valid, busy, ovf, resync}, {16'd0, e});
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    repeat (3) tick();
    chk("reset_state", st, 3'd0);
    chk("reset_zero", zero, 1'b1);
    chk("reset_valid_busy", {valid, busy}, 2'b00);
    chk("reset_ovf_resync", {ovf, resync}, 10'd0);
    rst_ni = 1'b1;
    tick();

    // run sampled at the next edge (edge 0)
    run = 1'b1;
    for (int n = 0; n <= 17; n++) begin
      tick();
      if (n == 7)  chk("last_flush", st, 3'd1);
      if (n == 8)  chk("first_fill", st, 3'd2);
      if (n == 16) chk("last_fill_valid", {st, valid}, {3'd2, 1'b0});
      if (n == 17) chk("first_run_valid", {st, valid, zero}, {3'd3, 1'b1, 1'b0});
    end

    l0 = 24'h010000; l1 = 24'hFF8000;
    tick();
    chk("ovf_lane0_only", ovf, 2'b01);
    l0 = 24'd0; l1 = 24'd0; clr = 1'b1;
    tick();
    chk("ovf_clear", ovf, 2'b00);
    l0 = 24'h010000;
    tick();
    chk("ovf_set_beats_clear", ovf, 2'b01);
    clr = 1'b0; l0 = 24'd0;

    sv = 1'b0;
    tick();
    chk("gap_to_flush", {st, valid, resync}, {3'd1, 1'b0, 8'd1});
    sv = 1'b1;
    for (int n = 1; n <= 17; n++) begin
      tick();
      if (n == 16) chk("resync_still_fill", st, 3'd2);
      if (n == 17) chk("resync_run_again", {st, valid}, {3'd3, 1'b1});
    end

    run = 1'b0; sv = 1'b0;
    tick();
    chk("stop_beats_gap", {st, zero, resync}, {3'd4, 1'b1, 8'd1});
    sv = 1'b1;
    for (int n = 1; n <= 9; n++) begin
      tick();
      if (n == 8) chk("last_drain", {st, zero, busy}, {3'd4, 1'b1, 1'b1});
      if (n == 9) chk("drain_to_idle", {st, busy}, {3'd0, 1'b0});
    end
    chk("ovf_survives_states", ovf, 2'b01);

    run = 1'b1;
    repeat (11) tick();
    chk("mid_fill", st, 3'd2);
    #1 rst_ni = 1'b0;
    #1 chk("async_reset", {st, zero, valid, busy, ovf, resync}, {3'd0, 1'b1, 1'b0, 1'b0, 2'b00, 8'd0});
    tick();
    rst_ni = 1'b1;
    repeat (9) tick();
    for (int i = 0; i < 300; i++) begin
      sv = 1'b0;
      tick();
      sv = 1'b1;
      repeat (8) tick();
    end
    chk("resync_saturated", {st, resync}, {3'd2, 8'd255});
    for (int i = 0; i < 3; i++) begin
      sv = 1'b0;
      tick();
      sv = 1'b1;
      repeat (8) tick();
    end
    chk("resync_holds", resync, 8'd255);

    for (int c = 0; c < 1500; c++) begin
      int sel;
      run = ($urandom_range(0, 39) != 0);
      sv  = ($urandom_range(0, 19) != 0);
      clr = ($urandom_range(0, 49) == 0);
      for (int k = 0; k < 2; k++) begin
        logic [23:0] v;
        sel = $urandom_range(0, 7);
        case (sel)
          0: v = 24'h007FFF;
          1: v = 24'h008000;
          2: v = 24'hFF8000;
          3: v = 24'hFF7FFF;
          4, 5: v = 24'($signed($urandom_range(0, 65535)) - 32768);
          default: v = 24'($urandom);
        endcase
        if (k == 0) l0 = v; else l1 = v;
      end
      tick();
    end

    run = 1'b0; clr = 1'b0;
    repeat (30) tick();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
